pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for an NSTAGES-deep in-order core.
//  Turns per-stage dependency flags into back-propagated stalls, bubbles and flushes.
//  Handles redirects (branch/jump) from any stage, including deferral while older
//  stages stall, and trap flushes. Adds a post-reset init flush, a stall watchdog
//  and stall/flush event counters.
//  Sits beside the datapath; stage 0 = IF (youngest), NSTAGES-1 = oldest.
// PARAMETERS
//  NSTAGES      4     pipeline stages, >=2
//  CNT_W        32    width of event counters
//  WD_LIMIT     1024  consecutive stage-0 stall cycles before o_watchdog, >=1
//  INIT_CYCLES  2     cycles of full flush after reset release, 0 = none
// PORTS
//  i_clk               in   1              clock, rising edge
//  i_reset             in   1              asynchronous, active-low reset
//  i_dep               in   NSTAGES        stage i cannot complete this cycle
//  i_redirect          in   1              redirect resolved this cycle
//  i_redirect_stage    in   $clog2(NSTAGES) index k of the resolving stage
//  i_trap              in   1              trap taken by oldest stage
//  i_cnt_clear         in   1              synchronous counter clear
//  o_stall             out  NSTAGES        stage i holds its register
//  o_flush             out  NSTAGES        stage i contents killed (reg loads bubble)
//  o_bubble            out  NSTAGES-1      reg between stage i and i+1 loads bubble
//  o_redirect_pending  out  1              deferred redirect held
//  o_init              out  1              init flush in progress
//  o_watchdog          out  1              stall watchdog tripped (registered)
//  o_stall_cycles      out  CNT_W          count of cycles with o_stall[0]=1
//  o_flush_events      out  CNT_W          count of redirect/trap flush events
// BEHAVIOUR
//  Reset (async, i_reset=0):
//  - init_cnt=INIT_CYCLES; pending, wd_cnt and counters are 0.
//  - o_watchdog=0, o_redirect_pending=0, counters=0.
//  - o_init=1, o_flush=all ones, o_stall=0, o_bubble=0 if INIT_CYCLES>0.
//  - Mid-operation assertion aborts everything immediately.
//  Init: while init_cnt!=0: o_init=1, o_flush all 1, o_stall/o_bubble 0,
//  - i_dep/i_redirect/i_trap ignored.
//  - Decrement per cycle.
//  - Counters and watchdog do not advance.
//  Stall chain (combinational):
//  - s[N-1]=i_dep[N-1]; s[i]=i_dep[i]|s[i+1].
//  - o_stall[i]=s[i] unless flushed.
//  Bubble:
//  - o_bubble[i]=s[i]&~s[i+1]&~o_flush[i+1] for i<N-1.
//  Redirect, stage k = new if i_redirect, else stored:
//  - Acts when k==N-1 or s[k+1]==0: o_flush[i]=1 and o_stall[i]=0 for all i<k.
//  - On acting, pending clears and o_flush_events +1.
//  - Blocked by an older stall: stores k, sets pending, no flush.
//  - Pending acts on the first cycle s[k+1]==0.
//  - New i_redirect with stage >= stored k replaces it; a younger one is dropped.
//  Trap (highest priority):
//  - o_flush[i]=1 and o_stall[i]=0 for i<N-1.
//  - o_stall[N-1]=i_dep[N-1], flush[N-1]=0.
//  - Clears pending, ignores i_redirect, o_flush_events +1.
//  Watchdog:
//  - wd_cnt +1 (saturating at WD_LIMIT) each cycle o_stall[0]=1; else 0.
//  - o_watchdog is a register, equal to (wd_cnt==WD_LIMIT) one cycle later.
//  Counters:
//  - Wrap modulo 2^CNT_W.
//  - i_cnt_clear zeroes both at the next edge and wins over increment.
// TESTING
//  1 Reset release, INIT_CYCLES=2 -> o_init/o_flush=4'hF two cycles, then o_flush=0, o_init=0.
//  2 N=4, i_dep=4'b0100 -> o_stall=4'b0111, o_bubble=3'b100, o_stall_cycles +1/cycle.
//  3 i_redirect k=2 with i_dep=0 -> o_flush=4'b0011 same cycle, o_flush_events=1.
//  4 Redirect k=1, i_dep[3]=1 for 3 cycles -> pending=1, no flush; flush=4'b0001 when dep drops.
//  5 i_trap with i_dep=4'b1010 -> o_flush=4'b0111, o_stall=4'b1000, pending cleared.
//  6 WD_LIMIT=4, i_dep[0] held -> o_watchdog=1 on the 5th cycle; drop dep, clear next cycle.
//    Reset mid-stall -> all reset values at once.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard controller for an in-order pipeline: per-stage dependency flags become
// stalls, bubbles and flushes, with redirect deferral, trap flush, init flush and a stall watchdog.
module pipeline_ctrl #(
    parameter int NSTAGES     = 4,
    parameter int CNT_W       = 32,
    parameter int WD_LIMIT    = 1024,
    parameter int INIT_CYCLES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NSTAGES-1:0]         i_dep,
    input  logic                       i_redirect,
    input  logic [$clog2(NSTAGES)-1:0] i_redirect_stage,
    input  logic                       i_trap,
    input  logic                       i_cnt_clear,
    output logic [NSTAGES-1:0]         o_stall,
    output logic [NSTAGES-1:0]         o_flush,
    output logic [NSTAGES-2:0]         o_bubble,
    output logic                       o_redirect_pending,
    output logic                       o_init,
    output logic                       o_watchdog,
    output logic [CNT_W-1:0]           o_stall_cycles,
    output logic [CNT_W-1:0]           o_flush_events
);
    localparam int KW = $clog2(NSTAGES);
    localparam int WW = $clog2(WD_LIMIT + 1);
    localparam int IW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_MAX    = WW'(WD_LIMIT);
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES);

    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic             pend_q, pend_d;
    logic [KW-1:0]    pend_k_q, pend_k_d;
    logic [WW-1:0]    wd_cnt_q, wd_cnt_d;
    logic             watchdog_q, watchdog_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic               init_active;
    logic [NSTAGES-1:0] s;
    logic [NSTAGES-1:0] flush;
    logic [KW-1:0]      k;
    logic               blocked;
    logic               flush_evt;

    always_comb begin
        // s[i]: stage i must hold because it or any older stage cannot complete
        s[NSTAGES-1] = i_dep[NSTAGES-1];
        for (int i = NSTAGES - 2; i >= 0; i--) begin
            s[i] = i_dep[i] | s[i+1];
        end

        init_active = (init_cnt_q != '0);

        // a younger new redirect never displaces an older deferred one
        if (i_redirect && (!pend_q || (i_redirect_stage >= pend_k_q))) begin
            k = i_redirect_stage;
        end else begin
            k = pend_k_q;
        end

        blocked = 1'b0;
        for (int i = 0; i < NSTAGES - 1; i++) begin
            if (k == KW'(i)) blocked = s[i+1];
        end

        flush     = '0;
        flush_evt = 1'b0;
        pend_d    = pend_q;
        pend_k_d  = pend_k_q;
        if (init_active) begin
            flush = '1;
        end else if (i_trap) begin
            flush     = {1'b0, {(NSTAGES-1){1'b1}}};
            flush_evt = 1'b1;
            pend_d    = 1'b0;
        end else if (i_redirect || pend_q) begin
            if (blocked) begin
                pend_d   = 1'b1;
                pend_k_d = k;
            end else begin
                for (int i = 0; i < NSTAGES; i++) begin
                    if (KW'(i) < k) flush[i] = 1'b1;
                end
                flush_evt = 1'b1;
                pend_d    = 1'b0;
            end
        end

        o_flush = flush;
        o_stall = s & ~flush;
        for (int i = 0; i < NSTAGES - 1; i++) begin
            o_bubble[i] = s[i] & ~s[i+1] & ~flush[i+1];
        end

        init_cnt_d     = init_active ? (init_cnt_q - IW'(1)) : init_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        watchdog_d     = watchdog_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!init_active) begin
            if (o_stall[0]) begin
                wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : (wd_cnt_q + WW'(1));
            end else begin
                wd_cnt_d = '0;
            end
            watchdog_d = (wd_cnt_d == WD_MAX);
            if (o_stall[0]) stall_cycles_d = stall_cycles_q + CNT_W'(1);
            if (flush_evt)  flush_events_d = flush_events_q + CNT_W'(1);
        end
        if (i_cnt_clear) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            init_cnt_q     <= INIT_LOAD;
            pend_q         <= 1'b0;
            pend_k_q       <= '0;
            wd_cnt_q       <= '0;
            watchdog_q     <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            init_cnt_q     <= init_cnt_d;
            pend_q         <= pend_d;
            pend_k_q       <= pend_k_d;
            wd_cnt_q       <= wd_cnt_d;
            watchdog_q     <= watchdog_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign o_redirect_pending = pend_q;
    assign o_init             = init_active;
    assign o_watchdog         = watchdog_q;
    assign o_stall_cycles     = stall_cycles_q;
    assign o_flush_events     = flush_events_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed literal checks plus randomized traffic against a
// behavioural model built from the oldest-dependency rule.
module tb_pipeline_ctrl;
    localparam int N     = 4;
    localparam int LIM   = 4;
    localparam int INITC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dep = '0;
    logic       rd  = 1'b0;
    logic [1:0] st  = '0;
    logic       tr  = 1'b0;
    logic       clr = 1'b0;

    logic [3:0] o_stall, o_flush;
    logic [2:0] o_bubble;
    logic       o_pend, o_init, o_wd;
    logic [7:0] o_scnt, o_fcnt;

    int n_chk = 0;
    int n_err = 0;

    pipeline_ctrl #(.NSTAGES(N), .CNT_W(8), .WD_LIMIT(LIM), .INIT_CYCLES(INITC)) dut (
        .i_clk(clk), .i_reset(rst), .i_dep(dep), .i_redirect(rd),
        .i_redirect_stage(st), .i_trap(tr), .i_cnt_clear(clr),
        .o_stall(o_stall), .o_flush(o_flush), .o_bubble(o_bubble),
        .o_redirect_pending(o_pend), .o_init(o_init), .o_watchdog(o_wd),
        .o_stall_cycles(o_scnt), .o_flush_events(o_fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic r, input logic [1:0] s,
                         input logic t, input logic c);
        @(posedge clk);
        #1;
        dep = d; rd = r; st = s; tr = t; clr = c;
        #1;
    endtask

    // Model: stage i stalls iff some stage at or above i has a dependency,
    // i.e. i <= index of the oldest stage with i_dep set.
    initial begin : model
        int init_left, pend_k, wd, hi, k;
        int n_init, n_pk, n_wd;
        bit pend, wdog, evt, n_pend, n_wdog;
        logic [7:0] scnt, fcnt, n_scnt, n_fcnt;
        logic [3:0] e_flush, e_stall;
        logic [2:0] e_bub;
        init_left = INITC; pend = 0; pend_k = 0; wd = 0; wdog = 0; scnt = 0; fcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                init_left = INITC; pend = 0; pend_k = 0; wd = 0; wdog = 0; scnt = 0; fcnt = 0;
            end
            hi = -1;
            for (int i = 0; i < N; i++) if (dep[i]) hi = i;
            e_flush = '0; evt = 0; n_pend = pend; n_pk = pend_k;
            if (init_left > 0) begin
                e_flush = 4'hF;
            end else if (tr) begin
                for (int i = 0; i < N - 1; i++) e_flush[i] = 1'b1;
                evt = 1; n_pend = 0;
            end else if (rd || pend) begin
                k = pend_k;
                if (rd && (!pend || int'(st) >= pend_k)) k = int'(st);
                if (k < N - 1 && hi > k) begin
                    n_pend = 1; n_pk = k;
                end else begin
                    for (int i = 0; i < k; i++) e_flush[i] = 1'b1;
                    evt = 1; n_pend = 0;
                end
            end
            e_stall = '0; e_bub = '0;
            for (int i = 0; i < N; i++) if (i <= hi && !e_flush[i]) e_stall[i] = 1'b1;
            for (int i = 0; i < N - 1; i++) if (i == hi && !e_flush[i+1]) e_bub[i] = 1'b1;

            chk("m_flush", 32'(o_flush), 32'(e_flush));
            chk("m_stall", 32'(o_stall), 32'(e_stall));
            chk("m_bubble", 32'(o_bubble), 32'(e_bub));
            chk("m_pending", 32'(o_pend), 32'(pend));
            chk("m_init", 32'(o_init), 32'(init_left > 0));
            chk("m_watchdog", 32'(o_wd), 32'(wdog));
            chk("m_stall_cycles", 32'(o_scnt), 32'(scnt));
            chk("m_flush_events", 32'(o_fcnt), 32'(fcnt));

            n_init = init_left; n_wd = wd; n_wdog = wdog; n_scnt = scnt; n_fcnt = fcnt;
            if (init_left > 0) begin
                n_init = init_left - 1;
            end else begin
                n_wd = e_stall[0] ? ((wd < LIM) ? wd + 1 : LIM) : 0;
                n_wdog = (n_wd == LIM);
                if (e_stall[0]) n_scnt = scnt + 8'd1;
                if (evt) n_fcnt = fcnt + 8'd1;
            end
            if (clr) begin n_scnt = '0; n_fcnt = '0; end

            @(posedge clk or negedge rst);
            if (!rst) begin
                init_left = INITC; pend = 0; pend_k = 0; wd = 0; wdog = 0; scnt = 0; fcnt = 0;
            end else begin
                init_left = n_init; pend = n_pend; pend_k = n_pk; wd = n_wd; wdog = n_wdog;
                scnt = n_scnt; fcnt = n_fcnt;
            end
        end
    end

    initial begin : stim
        logic [3:0] d;
        int dens;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_flush", 32'(o_flush), 32'h0F);
        chk("rst_init", 32'(o_init), 32'h1);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_bubble", 32'(o_bubble), 32'h0);

        @(negedge clk); #2; rst = 1'b1; #1;
        chk("init_c1", 32'({o_init, o_flush}), 32'h1F);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("init_c2", 32'({o_init, o_flush}), 32'h1F);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("init_done", 32'({o_init, o_flush, o_stall}), 32'h000);

        drive(4'b0000, 0, 2'd0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0100, 0, 2'd0, 0, 0);
            chk("dep2_stall", 32'(o_stall), 32'h7);
            chk("dep2_bubble", 32'(o_bubble), 32'h4);
            chk("dep2_cnt", 32'(o_scnt), 32'(c));
        end
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("dep2_cnt_end", 32'(o_scnt), 32'd3);
        chk("dep2_fev", 32'(o_fcnt), 32'd0);

        drive(4'b0000, 1, 2'd2, 0, 0);
        chk("rd2_flush", 32'(o_flush), 32'h3);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("rd2_fev", 32'(o_fcnt), 32'd1);

        drive(4'b1000, 1, 2'd1, 0, 0);
        chk("rd1_blk_flush", 32'(o_flush), 32'h0);
        chk("rd1_blk_stall", 32'(o_stall), 32'hF);
        repeat (2) begin
            drive(4'b1000, 0, 2'd0, 0, 0);
            chk("rd1_pend", 32'(o_pend), 32'h1);
            chk("rd1_pend_flush", 32'(o_flush), 32'h0);
        end
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("rd1_release", 32'(o_flush), 32'h1);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("rd1_cleared", 32'({o_pend, o_fcnt}), 32'h002);

        drive(4'b1000, 1, 2'd2, 0, 0);
        drive(4'b1010, 1, 2'd1, 1, 0);
        chk("trap_pend_before", 32'(o_pend), 32'h1);
        chk("trap_flush", 32'(o_flush), 32'h7);
        chk("trap_stall", 32'(o_stall), 32'h8);
        chk("trap_bubble", 32'(o_bubble), 32'h0);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("trap_after", 32'({o_pend, o_fcnt}), 32'h003);

        for (int c = 1; c <= 6; c++) begin
            drive(4'b0001, 0, 2'd0, 0, 0);
            chk("wd_trip", 32'(o_wd), 32'(c >= 5));
        end
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("wd_hold", 32'(o_wd), 32'h1);
        drive(4'b0000, 0, 2'd0, 0, 0);
        chk("wd_clear", 32'(o_wd), 32'h0);

        drive(4'b1000, 1, 2'd0, 0, 0);
        repeat (5) drive(4'b1000, 0, 2'd0, 0, 0);
        chk("pre_rst", 32'({o_pend, o_wd}), 32'h3);
        #1; rst = 1'b0; #1;
        chk("mid_rst_flags", 32'({o_pend, o_wd, o_init}), 32'h1);
        chk("mid_rst_flush", 32'({o_flush, o_stall, o_bubble}), 32'h780);
        chk("mid_rst_cnt", 32'({o_scnt, o_fcnt}), 32'h0);
        @(negedge clk); #2; rst = 1'b1;

        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(1, 3);
            if (blk == 5 || blk == 10) begin
                @(posedge clk); #3; rst = 1'b0;
                @(negedge clk); #2; rst = 1'b1;
            end
            for (int c = 0; c < 200; c++) begin
                for (int b = 0; b < 4; b++) d[b] = ($urandom_range(0, 7) < dens);
                drive(d, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
            end
        end
        drive(4'b0000, 0, 2'd0, 0, 0);
        @(negedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
